// File: rtl/button_port.sv
// button_port: four active-low push buttons with synchronizer, per-key
// debounce, press-pending flags with write-one-to-clear, interrupt mask,
// 8-bit press counter, and a small combinational read window.
module button_port #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_n,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [15:0] CNT_MAX = 16'(DB_CYCLES - 1);

    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  sync2_q, sync2_d;
    logic [3:0]  level_q, level_d;
    logic [15:0] cnt_q [4];
    logic [15:0] cnt_d [4];
    logic [3:0]  pend_q, pend_d;
    logic [3:0]  mask_q, mask_d;
    logic [7:0]  count_q, count_d;
    logic [3:0]  arm_q, arm_d;
    logic [1:0]  warm_q, warm_d;

    logic [3:0]  pressed_raw;
    logic [3:0]  press;
    logic [2:0]  press_cnt;
    logic        wr_pend, wr_mask, wr_count;
    logic        unused_wdata;

    // Upper write-data bits carry no register state.
    always_comb unused_wdata = ^wdata[31:4];

    // Two-flop synchronizer feed; sync2 holds the sampled button image.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
    end

    // Per-key stability counter and debounced level (1 = pressed).
    always_comb begin
        pressed_raw = ~sync2_q;
        level_d     = level_q;
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (pressed_raw[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] < CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end else begin
                level_d[i] = pressed_raw[i];
                cnt_d[i]   = '0;
            end
        end
    end

    // A key is armed once it has been seen released after reset, so a key
    // held through reset re-qualifies its level without reporting a press.
    // warm_q skips the first two edges while sync2 still shows reset values.
    always_comb begin
        warm_d = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
        arm_d  = arm_q | ({4{warm_q == 2'd2}} & sync2_q);
    end

    // Press events and number of keys pressed on this edge.
    always_comb begin
        press     = level_d & ~level_q & arm_q;
        press_cnt = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            press_cnt = press_cnt + {2'b00, press[i]};
        end
    end

    // Register writes: W1C pending (press wins), mask load, count clear.
    always_comb begin
        wr_pend  = sel && we && (addr == 2'd1);
        wr_mask  = sel && we && (addr == 2'd2);
        wr_count = sel && we && (addr == 2'd3);
        pend_d   = (pend_q & ~(wr_pend ? wdata[3:0] : 4'b0000)) | press;
        mask_d   = wr_mask ? wdata[3:0] : mask_q;
        count_d  = (wr_count ? 8'd0 : count_q) + {5'd0, press_cnt};
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            level_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            pend_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
            arm_q   <= '0;
            warm_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            arm_q   <= arm_d;
            warm_q  <= warm_d;
        end
    end

    // Read mux; zero when not selected.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                2'd0:    rdata = {28'd0, level_q};
                2'd1:    rdata = {28'd0, pend_q};
                2'd2:    rdata = {28'd0, mask_q};
                default: rdata = {24'd0, count_q};
            endcase
        end
    end

    // Interrupt formed only from registered pending and mask bits.
    always_comb irq = |(pend_q & mask_q);

endmodule

// File: doc/button_port.md
BUTTON_PORT -- requirements
Module: button_port

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 16, meaning consecutive stable cycles required before a debounced level changes (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port key_n  input  4  raw push buttons, active-low, asynchronous to clk.
REQ-005 SHALL have port sel  input  1  bus select for this peripheral's register window.
REQ-006 SHALL have port addr  input  2  register index: 0 STATE, 1 PEND, 2 MASK, 3 COUNT.
REQ-007 SHALL have port we  input  1  write strobe, qualified by sel.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  read data, combinational from addr and registers.
REQ-010 SHALL have port irq  output  1  level interrupt request.

Function
REQ-011 SHALL pass each key_n bit through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-012 SHALL keep, per key, a debounced level bit (1 = pressed = inverted sync2) and a 16-bit stability counter.
REQ-013 SHALL, per key, when inverted sync2 equals level: clear that key's counter to 0.
REQ-014 SHALL, per key, when inverted sync2 differs from level and counter < DB_CYCLES-1: increment counter.
REQ-015 SHALL, per key, when inverted sync2 differs from level and counter == DB_CYCLES-1: load level from inverted sync2 and clear counter.
REQ-016 SHALL therefore change level on the (DB_CYCLES+2)th rising edge after key_n is first sampled at its new value, provided key_n stays stable throughout.
REQ-017 SHALL suppress any glitch shorter than DB_CYCLES cycles after synchronization; level SHALL remain unchanged.
REQ-018 SHALL detect a press as a level bit transitioning 0->1; releases (1->0) SHALL generate no event.
REQ-019 SHALL, on each press, set the corresponding PEND bit on the same edge that level updates.
REQ-020 SHALL, on each press, add to COUNT (8 bits, wraps 255->0) the number of keys pressed on that edge (0..4).
REQ-021 SHALL, on a write (sel & we) to addr 1, clear each PEND bit whose wdata[3:0] bit is 1 (write-one-to-clear).
REQ-022 SHALL give a press priority over a same-cycle W1C clear of the same bit; the bit ends set.
REQ-023 SHALL, on a write to addr 2, load MASK with wdata[3:0].
REQ-024 SHALL, on a write to addr 3, clear COUNT; a same-cycle press SHALL leave COUNT equal to that cycle's press count.
REQ-025 SHALL ignore writes to addr 0.
REQ-026 SHALL drive rdata, when sel=1: addr 0 {28'b0, level}; addr 1 {28'b0, PEND}; addr 2 {28'b0, MASK}; addr 3 {24'b0, COUNT}.
REQ-027 SHALL drive rdata to 0 when sel=0.
REQ-028 SHALL have reads with no side effects.
REQ-029 SHALL drive irq = OR of (PEND & MASK), derived only from flops (glitch-free).

Reset
REQ-030 SHALL, while reset=1, set sync1 and sync2 to 1 (released), and clear level, counters, PEND, MASK and COUNT.
REQ-031 SHALL therefore present rdata=0 for every addr and irq=0 during and immediately after reset.
REQ-032 SHALL discard reset asserted mid-debounce: partial counts are lost, and no press is reported for a key held through reset until it is released and pressed again.
REQ-033 SHALL NOT report a held key as a press after reset deasserts: level re-qualifies it (REQ-015), but PEND and COUNT SHALL update only on 0->1 transitions of level.

Verification (DB_CYCLES=4)
REQ-034 SHALL cover: key_n[0] 1->0 held stable -> STATE reads 0x1 starting at the 6th edge after first sample; PEND=0x1; COUNT=1.
REQ-035 SHALL cover: key_n[2] low pulse lasting 3 sampled cycles -> STATE, PEND and COUNT remain 0.
REQ-036 SHALL cover: MASK=0x1 with key 0 pressed -> irq=1; write 0x1 to addr 1 -> irq=0 next cycle; key 1 pressed with MASK=0x1 -> PEND=0x2 and irq=0.
REQ-037 SHALL cover: all four keys pressed on the same edge -> PEND=0xF, COUNT increments by 4; with COUNT=254 beforehand, COUNT=2 afterward.
REQ-038 SHALL cover: W1C of 0x1 to addr 1 on the same edge key 0's press lands -> PEND[0]=1; COUNT write on that edge -> COUNT=1.
REQ-039 SHALL cover: reset pulsed with key 3 held and counter mid-count -> all reads 0; after release, key 3 held -> STATE=0x8 after 6 edges, PEND=0, COUNT=0.
